// File: rtl/edge_detect_bank.sv
// edge_detect_bank
//   Multi-channel edge detector for asynchronous board inputs (switches,
//   buttons, external strobes). Each channel is synchronised, debounced and
//   then edge-detected according to a shared mode. Every accepted edge gives
//   a registered one-cycle pulse and sets a sticky pending flag. A saturating
//   counter totals all pulses across all channels.
//
// Ports
//   clk         system clock, all logic on posedge
//   rst         asynchronous active-high reset
//   din         raw asynchronous channel inputs [CH]
//   mode        00 rising, 01 falling, 10 both edges, 11 detection disabled
//   clr         per-channel pending clear, sampled on clk [CH]
//   count_clr   clears the event counter, sampled on clk
//   pulse       registered one-cycle edge pulse per channel [CH]
//   pending     sticky per-channel event flag [CH]
//   any_pending OR of all pending flags
//   evt_count   saturating total of pulses across all channels [CNT_W]

module edge_detect_bank #(
    parameter int CH          = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 4,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CH-1:0]    din,
    input  logic [1:0]       mode,
    input  logic [CH-1:0]    clr,
    input  logic             count_clr,
    output logic [CH-1:0]    pulse,
    output logic [CH-1:0]    pending,
    output logic             any_pending,
    output logic [CNT_W-1:0] evt_count
);

    typedef enum logic [1:0] {
        MODE_RISE = 2'b00,
        MODE_FALL = 2'b01,
        MODE_BOTH = 2'b10,
        MODE_OFF  = 2'b11
    } mode_e;

    localparam int              DB_W    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);
    localparam int              POP_W   = $clog2(CH + 1);
    // One spare bit above the wider operand so the sum can never wrap
    // before the saturation compare sees it.
    localparam int               SUM_W   = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;
    localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

    logic [CH-1:0]    sync_pipe [SYNC_STAGES];
    logic [CH-1:0]    sync;
    logic [CH-1:0]    stable;
    logic [DB_W-1:0]  db_cnt [CH];
    logic [CH-1:0]    accept;
    logic [CH-1:0]    hit;
    logic [POP_W-1:0] hit_count;
    logic [SUM_W-1:0] count_sum;
    logic [CNT_W-1:0] count_next;

    // Synchroniser chain, one shift register per channel bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_pipe[s] <= '0;
            end
        end else begin
            sync_pipe[0] <= din;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_pipe[s] <= sync_pipe[s-1];
            end
        end
    end

    assign sync = sync_pipe[SYNC_STAGES-1];

    // A channel accepts its new level on the edge where the differing level
    // has persisted for DB_CYCLES samples. Because the accepted level equals
    // sync, the direction of the edge is simply the value of sync.
    always_comb begin
        accept = '0;
        hit    = '0;
        for (int i = 0; i < CH; i++) begin
            accept[i] = (sync[i] != stable[i]) && (db_cnt[i] == DB_LAST);
        end
        case (mode)
            MODE_RISE: hit = accept & sync;
            MODE_FALL: hit = accept & ~sync;
            MODE_BOTH: hit = accept;
            default:   hit = '0;
        endcase
    end

    // count_clr drops the old total but still counts pulses landing on the
    // same edge, so no event is lost.
    always_comb begin
        hit_count = '0;
        for (int i = 0; i < CH; i++) begin
            hit_count = hit_count + POP_W'(hit[i]);
        end
        count_sum  = (count_clr ? SUM_W'(0) : SUM_W'(evt_count)) + SUM_W'(hit_count);
        count_next = (count_sum > CNT_MAX) ? {CNT_W{1'b1}} : count_sum[CNT_W-1:0];
    end

    // Debounce filter: any return to the stable level restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable <= '0;
            for (int i = 0; i < CH; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (sync[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (accept[i]) begin
                    stable[i] <= sync[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // Registered outputs. A new event wins over a clear on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pulse     <= '0;
            pending   <= '0;
            evt_count <= '0;
        end else begin
            pulse     <= hit;
            pending   <= (pending & ~clr) | hit;
            evt_count <= count_next;
        end
    end

    assign any_pending = |pending;

endmodule

// File: tb/tb_edge_detect_bank.sv
// tb_edge_detect_bank
//   Self-checking bench for edge_detect_bank (CH=8, SYNC_STAGES=2,
//   DB_CYCLES=4, CNT_W=4). A reference model pushes the expected outputs
//   after every clock edge into a queue; a monitor on the falling edge pops
//   and compares them against the DUT. Directed sequences cover reset,
//   latency, debounce, modes, clear priority, saturation and async reset,
//   followed by a randomised phase.

module tb_edge_detect_bank;

    localparam int CH          = 8;
    localparam int SYNC_STAGES = 2;
    localparam int DB_CYCLES   = 4;
    localparam int CNT_W       = 4;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    typedef struct {
        logic [CH-1:0] pulse;
        logic [CH-1:0] pending;
        int            count;
    } exp_t;

    logic             clk;
    logic             rst;
    logic [CH-1:0]    din;
    logic [1:0]       mode;
    logic [CH-1:0]    clr;
    logic             count_clr;
    logic [CH-1:0]    pulse;
    logic [CH-1:0]    pending;
    logic             any_pending;
    logic [CNT_W-1:0] evt_count;

    int vectors;
    int miscompares;

    exp_t exp_q [$];
    bit   mon_armed;

    // Reference model state: a delay line of sampled inputs, the accepted
    // level per channel and the length of the current run of differing samples.
    logic [CH-1:0] m_delay [$];
    logic [CH-1:0] m_stable;
    int            m_run [CH];
    logic [CH-1:0] m_pending;
    int            m_count;

    edge_detect_bank #(
        .CH          (CH),
        .SYNC_STAGES (SYNC_STAGES),
        .DB_CYCLES   (DB_CYCLES),
        .CNT_W       (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .mode        (mode),
        .clr         (clr),
        .count_clr   (count_clr),
        .pulse       (pulse),
        .pending     (pending),
        .any_pending (any_pending),
        .evt_count   (evt_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
        end
    endtask

    // Inputs change 1 time unit after a rising edge and are held for the
    // requested number of edges; the task returns 1 unit after the last one.
    task automatic applyStimulus(input logic [CH-1:0] d, input logic [1:0] m,
                                 input logic [CH-1:0] c, input logic cc, input int cycles);
        din       = d;
        mode      = m;
        clr       = c;
        count_clr = cc;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    // Reference model: one expected entry per clock edge, or a single zero
    // entry whenever reset is (or becomes) active.
    always @(posedge clk or posedge rst) begin
        exp_t          e;
        logic [CH-1:0] lvl;
        logic [CH-1:0] events;
        logic [CH-1:0] pulse_e;
        int            base;
        if (rst) begin
            m_delay.delete();
            for (int s = 0; s < SYNC_STAGES; s++) m_delay.push_back('0);
            m_stable  = '0;
            for (int i = 0; i < CH; i++) m_run[i] = 0;
            m_pending = '0;
            m_count   = 0;
            exp_q.delete();
            e.pulse   = '0;
            e.pending = '0;
            e.count   = 0;
            exp_q.push_back(e);
            mon_armed = 1'b1;
        end else begin
            m_delay.push_back(din);
            lvl    = m_delay.pop_front();
            events = '0;
            for (int i = 0; i < CH; i++) begin
                if (lvl[i] != m_stable[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DB_CYCLES) begin
                        m_run[i]    = 0;
                        m_stable[i] = lvl[i];
                        events[i]   = 1'b1;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            case (mode)
                2'b00:   pulse_e = events & m_stable;
                2'b01:   pulse_e = events & ~m_stable;
                2'b10:   pulse_e = events;
                default: pulse_e = '0;
            endcase
            m_pending = (m_pending & ~clr) | pulse_e;
            base      = count_clr ? 0 : m_count;
            m_count   = base + $countones(pulse_e);
            if (m_count > CNT_MAX) m_count = CNT_MAX;
            e.pulse   = pulse_e;
            e.pending = m_pending;
            e.count   = m_count;
            exp_q.push_back(e);
        end
    end

    // Monitor: compares every cycle on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (mon_armed) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL scoreboard_underflow at %0t: got 0 entries, expected 1", $time);
            end else begin
                e = exp_q.pop_front();
                checkOutput("sb_pulse",       32'(pulse),       32'(e.pulse));
                checkOutput("sb_pending",     32'(pending),     32'(e.pending));
                checkOutput("sb_any_pending", 32'(any_pending), 32'(|e.pending));
                checkOutput("sb_evt_count",   32'(evt_count),   32'(e.count));
            end
        end
    end

    initial begin
        logic [CH-1:0] cur;
        logic [1:0]    rmode;
        int            t4_exp [4];
        t4_exp    = '{1, 1, 2, 0};
        vectors     = 0;
        miscompares = 0;
        mon_armed   = 1'b0;

        // Reset with all inputs high: outputs stay zero during reset.
        rst       = 1'b1;
        cur       = '1;
        din       = cur;
        mode      = 2'b00;
        clr       = '0;
        count_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("t1_reset_pulse", 32'(pulse), 32'h0);
        checkOutput("t1_reset_count", 32'(evt_count), 32'h0);
        rst = 1'b0;
        applyStimulus(cur, 2'b00, '0, 1'b0, 6);
        checkOutput("t1_pulse_all", 32'(pulse), 32'hFF);
        checkOutput("t1_count", 32'(evt_count), 32'd8);
        applyStimulus(cur, 2'b00, '0, 1'b0, 1);
        checkOutput("t1_pulse_once", 32'(pulse), 32'h0);
        applyStimulus(cur, 2'b00, '1, 1'b0, 1);
        cur = '0;
        applyStimulus(cur, 2'b00, '0, 1'b0, 10);
        checkOutput("t1_pending_cleared", 32'(any_pending), 32'h0);

        // Latency of a single rising edge on channel 0.
        cur = 8'h01;
        applyStimulus(cur, 2'b00, '0, 1'b0, 5);
        checkOutput("t2_no_early_pulse", 32'(pulse), 32'h0);
        applyStimulus(cur, 2'b00, '0, 1'b0, 1);
        checkOutput("t2_pulse", 32'(pulse), 32'h01);
        checkOutput("t2_any_pending", 32'(any_pending), 32'h1);
        applyStimulus(cur, 2'b00, '0, 1'b0, 1);
        checkOutput("t2_one_cycle", 32'(pulse), 32'h0);
        applyStimulus(cur, 2'b00, '0, 1'b0, 3);
        checkOutput("t2_pending_sticky", 32'(pending), 32'h01);
        applyStimulus(cur, 2'b00, 8'h01, 1'b0, 1);
        checkOutput("t2_pending_clr", 32'(pending), 32'h0);
        checkOutput("t2_any_pending_clr", 32'(any_pending), 32'h0);

        // Debounce: 3-cycle glitch rejected, 4-cycle level accepted.
        applyStimulus(cur | 8'h08, 2'b00, '0, 1'b0, 3);
        applyStimulus(cur, 2'b00, '0, 1'b0, 10);
        checkOutput("t3_glitch_rejected", 32'(pending), 32'h0);
        applyStimulus(cur | 8'h08, 2'b00, '0, 1'b0, 4);
        applyStimulus(cur, 2'b00, '0, 1'b0, 10);
        checkOutput("t3_level_accepted", 32'(pending), 32'h08);
        applyStimulus(cur, 2'b00, '1, 1'b0, 1);

        // Modes: one high-then-low toggle of channel 1 per mode.
        for (int m = 0; m < 4; m++) begin
            applyStimulus(cur, 2'(m), '0, 1'b1, 1);
            applyStimulus(cur | 8'h02, 2'(m), '0, 1'b0, 10);
            applyStimulus(cur, 2'(m), '0, 1'b0, 10);
            checkOutput($sformatf("t4_mode%0d_count", m), 32'(evt_count), 32'(t4_exp[m]));
        end

        // Clear on the same edge as a new event: the event wins.
        applyStimulus(cur | 8'h04, 2'b00, '0, 1'b0, 5);
        applyStimulus(cur | 8'h04, 2'b00, 8'h04, 1'b0, 1);
        checkOutput("t5_set_wins", 32'(pending[2]), 32'h1);
        applyStimulus(cur | 8'h04, 2'b00, 8'h04, 1'b0, 1);
        checkOutput("t5_clr_later", 32'(pending[2]), 32'h0);
        cur = cur | 8'h04;
        applyStimulus(cur, 2'b00, '0, 1'b0, 5);

        // Saturation: 24 events into a 4-bit counter.
        applyStimulus(cur, 2'b10, '1, 1'b1, 1);
        for (int k = 0; k < 3; k++) begin
            cur = ~cur;
            applyStimulus(cur, 2'b10, '0, 1'b0, 10);
        end
        checkOutput("t6_saturate", 32'(evt_count), 32'd15);

        // count_clr on the edge where two channels pulse.
        cur = cur ^ 8'h30;
        applyStimulus(cur, 2'b10, '0, 1'b0, 5);
        applyStimulus(cur, 2'b10, '0, 1'b1, 1);
        checkOutput("t6_clr_with_pulses", 32'(evt_count), 32'd2);
        applyStimulus(cur, 2'b10, '0, 1'b0, 5);

        // Asynchronous reset in the middle of a debounce.
        cur = cur ^ 8'h40;
        applyStimulus(cur, 2'b10, '0, 1'b0, 3);
        rst = 1'b1;
        #1;
        checkOutput("t6_async_count", 32'(evt_count), 32'h0);
        checkOutput("t6_async_pending", 32'(pending), 32'h0);
        cur = '0;
        applyStimulus(cur, 2'b10, '0, 1'b0, 2);
        rst = 1'b0;
        applyStimulus(cur, 2'b10, '0, 1'b0, 12);
        checkOutput("t6_no_pulse_after_reset", 32'(evt_count), 32'h0);

        // Randomised phase: sparse toggles give a mix of glitches and
        // accepted edges, with occasional mode changes, clears and resets.
        rmode = 2'b10;
        for (int n = 0; n < 400; n++) begin
            for (int b = 0; b < CH; b++) begin
                if ($urandom_range(0, 7) == 0) cur[b] = ~cur[b];
            end
            if ($urandom_range(0, 19) == 0) rmode = 2'($urandom_range(0, 3));
            rst = ($urandom_range(0, 199) == 0);
            applyStimulus(cur, rmode, CH'($urandom & $urandom & $urandom),
                          ($urandom_range(0, 31) == 0), 1);
        end
        rst = 1'b0;
        applyStimulus(cur, rmode, '0, 1'b0, 10);

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
